// File: rtl/lab4_branch_pkg.sv
// Shared types and default sizing for the bimodal predictor controller.
package lab4_branch_pkg;

    localparam int UPD_Q_DEPTH_DEF = 2;
    localparam int MAX_DEFER_DEF   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

    typedef enum logic {
        PRED_PRIO = 1'b0,
        UPD_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/branch_upd_queue.sv
// FIFO of resolved-branch updates: val/rdy enqueue, head/pop dequeue.
module branch_upd_queue
    import lab4_branch_pkg::*;
#(
    parameter int DEPTH = UPD_Q_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enq_val,
    output logic       enq_rdy,
    input  upd_entry_t enq_data,
    output upd_entry_t head,
    input  logic       pop,
    output logic       full,
    output logic       empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    upd_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_enq;
    logic          do_pop;

    // Full stalls the producer even when the head pops this same cycle.
    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign enq_rdy = !full;
    assign do_enq  = enq_val && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_enq, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/branch_bimodal_ctrl.sv
// Shares the PHT datapath PC port between fetch lookups and queued updates,
// with a bounded-starvation arbiter and saturating counter strobes.
module branch_bimodal_ctrl
    import lab4_branch_pkg::*;
#(
    parameter int UPD_Q_DEPTH = UPD_Q_DEPTH_DEF,
    parameter int MAX_DEFER   = MAX_DEFER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_req_val,
    output logic        pred_req_rdy,
    input  logic [31:0] pred_req_pc,
    output logic        pred_resp_val,
    input  logic        pred_resp_rdy,
    output logic        pred_resp_taken,
    input  logic        upd_req_val,
    output logic        upd_req_rdy,
    input  logic [31:0] upd_req_pc,
    input  logic        upd_req_taken,
    output logic [31:0] dpath_pc,
    input  logic        dpath_prediction,
    input  logic        entry_upper_reached,
    input  logic        entry_lower_reached,
    output logic        increment_entry,
    output logic        decrement_entry
);

    localparam int          CW        = $clog2(MAX_DEFER + 1);
    localparam logic [CW-1:0] DEFER_LIM = CW'(MAX_DEFER);

    function automatic logic sat_inc(input logic taken, input logic upper);
        return taken && !upper;
    endfunction

    function automatic logic sat_dec(input logic taken, input logic lower);
        return !taken && !lower;
    endfunction

    arb_state_t    state;
    logic [CW-1:0] defer_cnt;
    logic          vld_p1;
    logic          taken_p1;
    upd_entry_t    head;
    upd_entry_t    enq_data;
    logic          q_full;
    logic          q_empty;
    logic          q_enq_rdy;
    logic          resp_free;
    logic          pred_grant;
    logic          upd_grant;
    logic          enq_fire;

    assign enq_data = '{pc: upd_req_pc, taken: upd_req_taken};

    branch_upd_queue #(
        .DEPTH (UPD_Q_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (enq_fire),
        .enq_rdy  (q_enq_rdy),
        .enq_data (enq_data),
        .head     (head),
        .pop      (upd_grant),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Every grant and ready is qualified by reset so all outputs read 0 while it is low.
    assign resp_free   = !vld_p1 || pred_resp_rdy;
    assign pred_grant  = reset && (state == PRED_PRIO) && pred_req_val && resp_free;
    assign upd_grant   = reset && !q_empty && ((state == UPD_FORCE) || !pred_grant);
    assign upd_req_rdy = reset && q_enq_rdy && !q_full;
    assign enq_fire    = upd_req_val && upd_req_rdy;

    always_comb begin
        dpath_pc        = '0;
        increment_entry = 1'b0;
        decrement_entry = 1'b0;
        if (pred_grant) begin
            dpath_pc = pred_req_pc;
        end else if (upd_grant) begin
            dpath_pc        = head.pc;
            increment_entry = sat_inc(head.taken, entry_upper_reached);
            decrement_entry = sat_dec(head.taken, entry_lower_reached);
        end
    end

    assign pred_req_rdy    = pred_grant;
    assign pred_resp_val   = reset && vld_p1;
    assign pred_resp_taken = reset && vld_p1 && taken_p1;

    // Stage p1: response register, one lookup deep
    always_ff @(posedge clk) begin
        if (!reset)
            vld_p1 <= 1'b0;
        else if (pred_grant)
            vld_p1 <= 1'b1;
        else if (pred_resp_rdy)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (pred_grant) taken_p1 <= dpath_prediction;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= PRED_PRIO;
            defer_cnt <= '0;
        end else begin
            case (state)
                PRED_PRIO: begin
                    if (q_empty || upd_grant) begin
                        defer_cnt <= '0;
                    end else if (pred_grant) begin
                        defer_cnt <= defer_cnt + 1'b1;
                        if (defer_cnt + 1'b1 == DEFER_LIM) state <= UPD_FORCE;
                    end
                end
                UPD_FORCE: begin
                    defer_cnt <= '0;
                    state     <= PRED_PRIO;
                end
                default: begin
                    defer_cnt <= '0;
                    state     <= PRED_PRIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_bimodal_ctrl.sv
// Directed bench for branch_bimodal_ctrl with hand-computed expectations.
module tb_branch_bimodal_ctrl;

    logic        clk;
    logic        reset;
    logic        pred_req_val;
    logic        pred_req_rdy;
    logic [31:0] pred_req_pc;
    logic        pred_resp_val;
    logic        pred_resp_rdy;
    logic        pred_resp_taken;
    logic        upd_req_val;
    logic        upd_req_rdy;
    logic [31:0] upd_req_pc;
    logic        upd_req_taken;
    logic [31:0] dpath_pc;
    logic        dpath_prediction;
    logic        entry_upper_reached;
    logic        entry_lower_reached;
    logic        increment_entry;
    logic        decrement_entry;

    int checks = 0;
    int errors = 0;

    branch_bimodal_ctrl #(
        .UPD_Q_DEPTH (2),
        .MAX_DEFER   (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .pred_req_val        (pred_req_val),
        .pred_req_rdy        (pred_req_rdy),
        .pred_req_pc         (pred_req_pc),
        .pred_resp_val       (pred_resp_val),
        .pred_resp_rdy       (pred_resp_rdy),
        .pred_resp_taken     (pred_resp_taken),
        .upd_req_val         (upd_req_val),
        .upd_req_rdy         (upd_req_rdy),
        .upd_req_pc          (upd_req_pc),
        .upd_req_taken       (upd_req_taken),
        .dpath_pc            (dpath_pc),
        .dpath_prediction    (dpath_prediction),
        .entry_upper_reached (entry_upper_reached),
        .entry_lower_reached (entry_lower_reached),
        .increment_entry     (increment_entry),
        .decrement_entry     (decrement_entry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_req_val        = 1'b0;
        pred_req_pc         = 32'h0;
        pred_resp_rdy       = 1'b1;
        upd_req_val         = 1'b0;
        upd_req_pc          = 32'h0;
        upd_req_taken       = 1'b0;
        dpath_prediction    = 1'b0;
        entry_upper_reached = 1'b0;
        entry_lower_reached = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] outs;
        reset               = 1'b0;
        pred_req_val        = 1'b1;
        pred_req_pc         = 32'hDEAD_BEEF;
        pred_resp_rdy       = 1'b1;
        upd_req_val         = 1'b1;
        upd_req_pc          = 32'h1234_5678;
        upd_req_taken       = 1'b1;
        dpath_prediction    = 1'b1;
        entry_upper_reached = 1'b0;
        entry_lower_reached = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            outs = {pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy,
                    increment_entry, decrement_entry, dpath_pc};
            checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs_zero[%0d]: got %h want 0", i, outs); end
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        #1;
        checks++; if (upd_req_rdy !== 1'b1) begin errors++; $display("FAIL reset_upd_rdy: got %b want 1", upd_req_rdy); end
        checks++; if (pred_resp_val !== 1'b0) begin errors++; $display("FAIL reset_resp_val: got %b want 0", pred_resp_val); end
        checks++; if (dpath_pc !== 32'h0) begin errors++; $display("FAIL reset_dpath_idle: got %h want 0", dpath_pc); end
        tick();
    endtask

    task automatic test_lookup_latency();
        pred_req_val     = 1'b1;
        pred_req_pc      = 32'h100;
        dpath_prediction = 1'b1;
        #1;
        checks++; if (pred_req_rdy !== 1'b1) begin errors++; $display("FAIL lookup_rdy: got %b want 1", pred_req_rdy); end
        checks++; if (dpath_pc !== 32'h100) begin errors++; $display("FAIL lookup_pc: got %h want 100", dpath_pc); end
        checks++; if (pred_resp_val !== 1'b0) begin errors++; $display("FAIL lookup_resp_early: got %b want 0", pred_resp_val); end
        tick();
        pred_req_val     = 1'b0;
        dpath_prediction = 1'b0;
        #1;
        checks++; if (pred_resp_val !== 1'b1) begin errors++; $display("FAIL lookup_resp_val: got %b want 1", pred_resp_val); end
        checks++; if (pred_resp_taken !== 1'b1) begin errors++; $display("FAIL lookup_resp_taken: got %b want 1", pred_resp_taken); end
        tick();
        #1;
        checks++; if (pred_resp_val !== 1'b0) begin errors++; $display("FAIL lookup_resp_drained: got %b want 0", pred_resp_val); end
        tick();
    endtask

    task automatic test_saturation();
        // taken=1 at the upper limit: grant without increment
        upd_req_val = 1'b1; upd_req_pc = 32'h200; upd_req_taken = 1'b1;
        tick();
        upd_req_val = 1'b0; entry_upper_reached = 1'b1;
        #1;
        checks++; if (dpath_pc !== 32'h200) begin errors++; $display("FAIL sat_upper_pc: got %h want 200", dpath_pc); end
        checks++; if ({increment_entry, decrement_entry} !== 2'b00) begin errors++; $display("FAIL sat_upper_strobes: got %b want 00", {increment_entry, decrement_entry}); end
        tick();
        entry_upper_reached = 1'b0;
        #1;
        checks++; if (dpath_pc !== 32'h0) begin errors++; $display("FAIL sat_upper_popped: got %h want 0", dpath_pc); end
        // taken=0 above the lower limit: one-cycle decrement
        upd_req_val = 1'b1; upd_req_pc = 32'h204; upd_req_taken = 1'b0;
        tick();
        upd_req_val = 1'b0;
        #1;
        checks++; if (dpath_pc !== 32'h204) begin errors++; $display("FAIL sat_dec_pc: got %h want 204", dpath_pc); end
        checks++; if ({increment_entry, decrement_entry} !== 2'b01) begin errors++; $display("FAIL sat_dec_strobes: got %b want 01", {increment_entry, decrement_entry}); end
        tick();
        #1;
        checks++; if (decrement_entry !== 1'b0) begin errors++; $display("FAIL sat_dec_once: got %b want 0", decrement_entry); end
        // taken=1 below the upper limit: increment
        upd_req_val = 1'b1; upd_req_pc = 32'h208; upd_req_taken = 1'b1;
        tick();
        upd_req_val = 1'b0;
        #1;
        checks++; if ({increment_entry, decrement_entry} !== 2'b10) begin errors++; $display("FAIL sat_inc_strobes: got %b want 10", {increment_entry, decrement_entry}); end
        tick();
    endtask

    task automatic test_starvation();
        logic [31:0] pc;
        pred_req_val = 1'b1; pred_req_pc = 32'h400; pred_resp_rdy = 1'b1;
        upd_req_val = 1'b1; upd_req_pc = 32'h300; upd_req_taken = 1'b1;
        #1;
        checks++; if (pred_req_rdy !== 1'b1) begin errors++; $display("FAIL starve_first_lookup: got %b want 1", pred_req_rdy); end
        tick();
        upd_req_val = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pc = 32'h400 + 32'(4 * i);
            pred_req_pc = pc;
            #1;
            checks++; if (pred_req_rdy !== 1'b1 || dpath_pc !== pc) begin errors++; $display("FAIL starve_lookup[%0d]: rdy=%b pc=%h want rdy=1 pc=%h", i, pred_req_rdy, dpath_pc, pc); end
            tick();
        end
        pred_req_pc = 32'h420;
        #1;
        checks++; if (pred_req_rdy !== 1'b0) begin errors++; $display("FAIL starve_forced_rdy: got %b want 0", pred_req_rdy); end
        checks++; if (dpath_pc !== 32'h300) begin errors++; $display("FAIL starve_forced_pc: got %h want 300", dpath_pc); end
        checks++; if (increment_entry !== 1'b1) begin errors++; $display("FAIL starve_forced_inc: got %b want 1", increment_entry); end
        tick();
        #1;
        checks++; if (pred_req_rdy !== 1'b1 || dpath_pc !== 32'h420) begin errors++; $display("FAIL starve_resume: rdy=%b pc=%h want rdy=1 pc=420", pred_req_rdy, dpath_pc); end
        tick();
        pred_req_val = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        pred_req_val = 1'b1; pred_req_pc = 32'h500; dpath_prediction = 1'b1; pred_resp_rdy = 1'b1;
        upd_req_val = 1'b1; upd_req_pc = 32'h600; upd_req_taken = 1'b0;
        #1;
        checks++; if (pred_req_rdy !== 1'b1) begin errors++; $display("FAIL bp_first_lookup: got %b want 1", pred_req_rdy); end
        tick();
        upd_req_val = 1'b0; pred_req_pc = 32'h504; dpath_prediction = 1'b0; pred_resp_rdy = 1'b0;
        #1;
        checks++; if (pred_resp_val !== 1'b1 || pred_resp_taken !== 1'b1) begin errors++; $display("FAIL bp_resp: val=%b taken=%b want 1 1", pred_resp_val, pred_resp_taken); end
        checks++; if (pred_req_rdy !== 1'b0) begin errors++; $display("FAIL bp_req_blocked: got %b want 0", pred_req_rdy); end
        checks++; if (dpath_pc !== 32'h600 || decrement_entry !== 1'b1) begin errors++; $display("FAIL bp_upd_slot: pc=%h dec=%b want 600 1", dpath_pc, decrement_entry); end
        tick();
        #1;
        checks++; if (pred_resp_taken !== 1'b1 || pred_req_rdy !== 1'b0 || dpath_pc !== 32'h0) begin errors++; $display("FAIL bp_hold: taken=%b rdy=%b pc=%h want 1 0 0", pred_resp_taken, pred_req_rdy, dpath_pc); end
        tick();
        pred_resp_rdy = 1'b1;
        #1;
        checks++; if (pred_req_rdy !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", pred_req_rdy); end
        tick();
        pred_req_val = 1'b0;
        #1;
        checks++; if (pred_resp_val !== 1'b1 || pred_resp_taken !== 1'b0) begin errors++; $display("FAIL bp_new_resp: val=%b taken=%b want 1 0", pred_resp_val, pred_resp_taken); end
        tick();
    endtask

    task automatic test_queue_full();
        logic [31:0] upc [3];
        upc[0] = 32'h700; upc[1] = 32'h704; upc[2] = 32'h708;
        pred_req_val = 1'b1; pred_req_pc = 32'h800; pred_resp_rdy = 1'b1;
        upd_req_val = 1'b1; upd_req_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            upd_req_pc = upc[i];
            #1;
            checks++; if (upd_req_rdy !== 1'b1) begin errors++; $display("FAIL full_enq_ok[%0d]: got %b want 1", i, upd_req_rdy); end
            tick();
        end
        upd_req_pc = upc[2];
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (upd_req_rdy !== 1'b0) begin errors++; $display("FAIL full_stall[%0d]: got %b want 0", i, upd_req_rdy); end
            tick();
        end
        #1;
        checks++; if (upd_req_rdy !== 1'b0 || pred_req_rdy !== 1'b0 || dpath_pc !== upc[0]) begin errors++; $display("FAIL full_pop_cycle: urdy=%b prdy=%b pc=%h want 0 0 %h", upd_req_rdy, pred_req_rdy, dpath_pc, upc[0]); end
        tick();
        #1;
        checks++; if (upd_req_rdy !== 1'b1) begin errors++; $display("FAIL full_after_pop: got %b want 1", upd_req_rdy); end
        tick();
        pred_req_val = 1'b0; upd_req_val = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks++; if (dpath_pc !== upc[i]) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, dpath_pc, upc[i]); end
            tick();
        end
    endtask

    task automatic test_midop_reset();
        pred_req_val = 1'b1; pred_req_pc = 32'h900; pred_resp_rdy = 1'b1; dpath_prediction = 1'b1;
        upd_req_val = 1'b1; upd_req_pc = 32'hA00; upd_req_taken = 1'b1;
        tick();
        upd_req_pc = 32'hA04; upd_req_taken = 1'b0;
        #1;
        checks++; if (pred_resp_val !== 1'b1) begin errors++; $display("FAIL midrst_pre_resp: got %b want 1", pred_resp_val); end
        tick();
        reset = 1'b0;
        pred_req_val = 1'b0; upd_req_val = 1'b0;
        #1;
        checks++; if ({pred_resp_val, pred_resp_taken, upd_req_rdy, dpath_pc} !== '0) begin errors++; $display("FAIL midrst_outs_zero: val=%b upd_rdy=%b pc=%h want 0", pred_resp_val, upd_req_rdy, dpath_pc); end
        tick();
        reset = 1'b1;
        #1;
        checks++; if (pred_resp_val !== 1'b0) begin errors++; $display("FAIL midrst_resp_cleared: got %b want 0", pred_resp_val); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({increment_entry, decrement_entry} !== 2'b00 || dpath_pc !== 32'h0) begin errors++; $display("FAIL midrst_no_strobe[%0d]: inc=%b dec=%b pc=%h want 0 0 0", i, increment_entry, decrement_entry, dpath_pc); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_lookup_latency();
        test_saturation();
        test_starvation();
        test_backpressure();
        test_queue_full();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_bimodal_ctrl.md
Name: branch_bimodal_ctrl

Overview:
Controller that sequences the bimodal PHT datapath. The datapath has a single PC port, and this block shares it between two requesters: fetch-stage prediction lookups and execute-stage resolved-branch updates. It buffers updates in a small queue and arbitrates between the two requesters with a starvation bound. It also drives the datapath's saturating increment/decrement controls from its limit status signals.

Parameters:
UPD_Q_DEPTH, 2, number of entries in the update queue (power of 2, >=2)
MAX_DEFER, 4, consecutive cycles a pending update may lose arbitration before it is forced (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
pred_req_val  in  1  fetch lookup request valid
pred_req_rdy  out  1  lookup request accepted this cycle
pred_req_pc  in  32  PC to predict
pred_resp_val  out  1  prediction response valid
pred_resp_rdy  in  1  consumer ready for the response
pred_resp_taken  out  1  predicted direction (1 = taken)
upd_req_val  in  1  resolved-branch update valid
upd_req_rdy  out  1  update accepted into the queue
upd_req_pc  in  32  PC of the resolved branch
upd_req_taken  in  1  actual outcome
dpath_pc  out  32  PC driven to the datapath
dpath_prediction  in  1  datapath prediction (counter MSB)
entry_upper_reached  in  1  indexed counter == 3
entry_lower_reached  in  1  indexed counter == 0
increment_entry  out  1  datapath increment strobe
decrement_entry  out  1  datapath decrement strobe

Behaviour:
- Reset (reset==0 at posedge): queue empties, response register is invalidated, defer counter clears, FSM enters PRED_PRIO.
- While reset is low, every output is held at 0: pred_req_rdy, pred_resp_val, pred_resp_taken, upd_req_rdy, dpath_pc, increment_entry, decrement_entry. This applies to a reset that arrives mid-operation as well; in-flight queue and response contents are discarded.
- Update queue:
  - FIFO of {pc, taken}.
  - upd_req_rdy = !full. No full-cycle enqueue/dequeue bypass; a full queue stalls even if it pops the same cycle.
  - No empty bypass: an enqueued update becomes eligible for grant on the next cycle at the earliest.
- Response register:
  - One entry, pipelined.
  - resp_free = !pred_resp_val || pred_resp_rdy.
  - A lookup accepted in cycle N loads dpath_prediction at the edge ending N; pred_resp_val=1 in cycle N+1 (latency 1).
  - The register holds its value while pred_resp_val && !pred_resp_rdy.
- FSM states and grants:
  - PRED_PRIO: a lookup is granted if pred_req_val && resp_free; otherwise the queue head is granted if the queue is non-empty.
  - UPD_FORCE: the queue head is granted; pred_req_rdy=0.
- Grant effects:
  - Lookup grant: dpath_pc=pred_req_pc, pred_req_rdy=1, both strobes 0.
  - Update grant: dpath_pc=head.pc, pop at the edge.
    - increment_entry = head.taken && !entry_upper_reached.
    - decrement_entry = !head.taken && !entry_lower_reached.
    - At most one strobe is ever high.
  - No grant: dpath_pc=0, strobes 0, pred_req_rdy=0.
- Defer counter (width clog2(MAX_DEFER+1)):
  - Increments in PRED_PRIO when the queue is non-empty and a lookup wins.
  - Clears on any update grant or when the queue is empty.
  - When it reaches MAX_DEFER, the next state is UPD_FORCE.
- FSM transitions:
  - UPD_FORCE grants exactly one update, then returns to PRED_PRIO with the counter at 0.
  - If the queue is empty in UPD_FORCE (only possible after reset), it returns to PRED_PRIO.
- Ordering: updates apply in arrival order. A lookup granted the cycle after an update to the same index sees the updated counter.
- PC indexing is fully delegated to the datapath; this block never slices the PC.

Decomposition:
- Package lab4_branch_pkg holds:
  - the upd_entry_t packed struct {logic [31:0] pc; logic taken;};
  - the arb_state_t enum {PRED_PRIO, UPD_FORCE};
  - the default constants for UPD_Q_DEPTH and MAX_DEFER.
- One sub-module, branch_upd_queue: parameterised FIFO of upd_entry_t with val/rdy enqueue and a head/pop dequeue, exposing full/empty.
- The arbiter FSM, defer counter, response register and strobe logic live in branch_bimodal_ctrl.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all vals=1 -> all outputs 0; after reset=1, upd_req_rdy=1 and pred_resp_val=0.
- Lookup latency: pred_req_val=1, pc=0x100, dpath_prediction=1 in cycle N -> pred_req_rdy=1, dpath_pc=0x100 in N; pred_resp_val=1, pred_resp_taken=1 in N+1.
- Saturation:
  - update pc=0x200, taken=1, with entry_upper_reached=1 -> increment_entry=0 on grant and the entry pops.
  - taken=0, entry_lower_reached=0 -> decrement_entry=1 for exactly one cycle.
- Starvation, MAX_DEFER=4: one queued update plus pred_req_val=1 and pred_resp_rdy=1 every cycle -> 4 lookups granted, then one cycle with pred_req_rdy=0 and dpath_pc=update pc, then lookups resume.
- Backpressure:
  - pred_resp_rdy=0 after one response -> pred_resp_taken holds, pred_req_rdy=0, and a queued update is granted in the idle lookup slot.
  - Enqueue 3 updates with depth 2 -> third sees upd_req_rdy=0 until a pop.
- Mid-op reset: reset=0 with 2 queued updates and a valid response -> next cycle pred_resp_val=0 and no strobe ever fires for the discarded updates.
